// File: rtl/video_pattern_if.sv
// video_pattern_if
//   Bundles the control inputs and the timing/pixel outputs of the video
//   test-pattern generator.
//   master : the generator (takes pal/mode/col_mask, drives timing and RGB)
//   slave  : the consumer (drives the controls, receives timing and RGB)
//   Signals: pal, mode[1:0], col_mask[2:0] (controls); ce_pix, hblank,
//            vblank, hsync, vsync, r/g/b[DW-1:0], hcnt[15:0], vcnt[15:0],
//            frame_cnt[7:0] (outputs)
interface video_pattern_if #(
  parameter int DW = 8
);
  logic          pal;
  logic [1:0]    mode;
  logic [2:0]    col_mask;
  logic          ce_pix;
  logic          hblank;
  logic          vblank;
  logic          hsync;
  logic          vsync;
  logic [DW-1:0] r;
  logic [DW-1:0] g;
  logic [DW-1:0] b;
  logic [15:0]   hcnt;
  logic [15:0]   vcnt;
  logic [7:0]    frame_cnt;

  modport master (
    input  pal, mode, col_mask,
    output ce_pix, hblank, vblank, hsync, vsync, r, g, b, hcnt, vcnt, frame_cnt
  );

  modport slave (
    output pal, mode, col_mask,
    input  ce_pix, hblank, vblank, hsync, vsync, r, g, b, hcnt, vcnt, frame_cnt
  );
endinterface

// File: rtl/video_pattern_gen.sv
// video_pattern_gen
//   Video raster timing and test-pattern source. A clock divider produces a
//   registered pixel enable; on each enable the pixel at the current raster
//   position is computed and registered, then the raster advances.
//   Ports:
//     clk   : system clock
//     reset : asynchronous active-high reset
//     vid   : video_pattern_if.master (pal/mode/col_mask in; ce_pix, blanks,
//             syncs, r/g/b, hcnt/vcnt/frame_cnt out)
module video_pattern_gen #(
  parameter int DW        = 8,
  parameter int CE_DIV    = 4,
  parameter int H_ACTIVE  = 320,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 32,
  parameter int H_BP      = 32,
  parameter int V_ACTIVE  = 240,
  parameter int V_FP      = 4,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 15,
  parameter int PAL_EXTRA = 50
) (
  input  logic            clk,
  input  logic            reset,
  video_pattern_if.master vid
);
  localparam logic [15:0] H_ACT       = 16'(H_ACTIVE);
  localparam logic [15:0] H_ACT_LAST  = 16'(H_ACTIVE - 1);
  localparam logic [15:0] HS_START    = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END      = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] H_LAST      = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_ACT       = 16'(V_ACTIVE);
  localparam logic [15:0] V_ACT_LAST  = 16'(V_ACTIVE - 1);
  localparam logic [15:0] VS_START    = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END      = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] V_LAST_NTSC = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] V_LAST_PAL  = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP + PAL_EXTRA - 1);
  localparam logic [15:0] BAR_LAST    = 16'(H_ACTIVE / 8 - 1);
  localparam logic [15:0] CE_LAST     = 16'(CE_DIV - 1);
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  localparam logic [DW-1:0] FULL      = {DW{1'b1}};
  localparam logic [DW-1:0] ZERO      = {DW{1'b0}};

  // Fibonacci LFSR, taps 16,14,13,11, shifting left with feedback into bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic [15:0]   div;
  logic          ce;
  logic [15:0]   h;
  logic [15:0]   v;
  logic [7:0]    frame;
  logic [15:0]   lfsr;
  logic          pal_l;
  logic [1:0]    mode_l;
  logic [15:0]   bar_cnt;
  logic [2:0]    bar_idx;

  logic          pix_hblank;
  logic          pix_vblank;
  logic          pix_hsync;
  logic          pix_vsync;
  logic [DW-1:0] pix_r;
  logic [DW-1:0] pix_g;
  logic [DW-1:0] pix_b;

  logic [15:0]   v_last;
  logic          hb_n;
  logic          vb_n;
  logic          hs_n;
  logic          vs_n;
  logic          grid_on;
  logic [DW-1:0] r_n;
  logic [DW-1:0] g_n;
  logic [DW-1:0] b_n;

  // Pixel-enable divider: ce goes high on the CE_DIV-th edge after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= 16'd0;
      ce  <= 1'b0;
    end else begin
      ce  <= (div == CE_LAST);
      div <= (div == CE_LAST) ? 16'd0 : div + 16'd1;
    end
  end

  // Pixel value and timing flags for the current raster position
  always_comb begin
    r_n     = ZERO;
    g_n     = ZERO;
    b_n     = ZERO;
    v_last  = pal_l ? V_LAST_PAL : V_LAST_NTSC;
    hb_n    = (h >= H_ACT);
    vb_n    = (v >= V_ACT);
    hs_n    = (h >= HS_START) && (h < HS_END);
    vs_n    = (v >= VS_START) && (v < VS_END);
    grid_on = (h[3:0] == 4'h0) || (v[3:0] == 4'h0) ||
              (h == H_ACT_LAST) || (v == V_ACT_LAST);
    case (mode_l)
      2'd0: begin
        r_n = lfsr[15 -: DW];
        g_n = lfsr[15 -: DW];
        b_n = lfsr[15 -: DW];
      end
      2'd1: begin
        // Bar order white..black: R off when idx bit1 set, G off when
        // idx bit2 set, B off on odd bars
        r_n = bar_idx[1] ? ZERO : FULL;
        g_n = bar_idx[2] ? ZERO : FULL;
        b_n = bar_idx[0] ? ZERO : FULL;
      end
      2'd2: begin
        r_n = grid_on ? FULL : ZERO;
        g_n = grid_on ? FULL : ZERO;
        b_n = grid_on ? FULL : ZERO;
      end
      2'd3: begin
        r_n = h[DW-1:0];
        g_n = v[DW-1:0];
        b_n = DW'(frame);
      end
      default: begin
        r_n = ZERO;
        g_n = ZERO;
        b_n = ZERO;
      end
    endcase
    if (hb_n || vb_n) begin
      r_n = ZERO;
      g_n = ZERO;
      b_n = ZERO;
    end else begin
      r_n = r_n & {DW{vid.col_mask[2]}};
      g_n = g_n & {DW{vid.col_mask[1]}};
      b_n = b_n & {DW{vid.col_mask[0]}};
    end
  end

  // Raster position, frame count, per-frame pal/mode latches, pattern state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h       <= 16'd0;
      v       <= 16'd0;
      frame   <= 8'd0;
      lfsr    <= LFSR_SEED;
      pal_l   <= 1'b0;
      mode_l  <= 2'd0;
      bar_cnt <= 16'd0;
      bar_idx <= 3'd0;
    end else if (ce) begin
      lfsr <= lfsr_next(lfsr);
      if (h == H_LAST) begin
        h       <= 16'd0;
        bar_cnt <= 16'd0;
        bar_idx <= 3'd0;
        if (v == v_last) begin
          v      <= 16'd0;
          frame  <= frame + 8'd1;
          pal_l  <= vid.pal;
          mode_l <= vid.mode;
        end else begin
          v <= v + 16'd1;
        end
      end else begin
        h <= h + 16'd1;
        if (bar_cnt == BAR_LAST) begin
          bar_cnt <= 16'd0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_cnt <= bar_cnt + 16'd1;
        end
      end
    end
  end

  // Output registers load on each pixel enable and hold in between
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_hblank <= 1'b0;
      pix_vblank <= 1'b0;
      pix_hsync  <= 1'b0;
      pix_vsync  <= 1'b0;
      pix_r      <= ZERO;
      pix_g      <= ZERO;
      pix_b      <= ZERO;
    end else if (ce) begin
      pix_hblank <= hb_n;
      pix_vblank <= vb_n;
      pix_hsync  <= hs_n;
      pix_vsync  <= vs_n;
      pix_r      <= r_n;
      pix_g      <= g_n;
      pix_b      <= b_n;
    end
  end

  assign vid.ce_pix    = ce;
  assign vid.hblank    = pix_hblank;
  assign vid.vblank    = pix_vblank;
  assign vid.hsync     = pix_hsync;
  assign vid.vsync     = pix_vsync;
  assign vid.r         = pix_r;
  assign vid.g         = pix_g;
  assign vid.b         = pix_b;
  assign vid.hcnt      = h;
  assign vid.vcnt      = v;
  assign vid.frame_cnt = frame;
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen
//   Bench for video_pattern_gen with a small raster (24x12 NTSC, 24x14 PAL).
//   A pixel-level reference model steps with every clock and is compared
//   against all outputs each cycle; directed sections cover reset, frame
//   lengths, colour bars, gradient and grid; a randomized section varies
//   pal/mode/col_mask and injects a mid-frame reset.
module tb_video_pattern_gen;
  localparam int DW        = 8;
  localparam int CE_DIV    = 2;
  localparam int H_ACTIVE  = 16;
  localparam int H_FP      = 2;
  localparam int H_SYNC    = 2;
  localparam int H_BP      = 4;
  localparam int V_ACTIVE  = 8;
  localparam int V_FP      = 1;
  localparam int V_SYNC    = 1;
  localparam int V_BP      = 2;
  localparam int PAL_EXTRA = 2;
  localparam int H_TOT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT     = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  video_pattern_if #(.DW(DW)) vid ();

  video_pattern_gen #(
    .DW(DW), .CE_DIV(CE_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PAL_EXTRA(PAL_EXTRA)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vid(vid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_h, m_v, m_frame, m_cyc, m_mode;
  bit          m_ce, m_pal;
  logic [15:0] m_lfsr;
  bit          e_hb, e_vb, e_hs, e_vs;
  logic [23:0] e_rgb;

  function automatic logic [23:0] bar_colour(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_frame = 0; m_cyc = 0; m_mode = 0;
    m_ce = 1'b0; m_pal = 1'b0; m_lfsr = 16'hACE1;
    e_hb = 1'b0; e_vb = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_rgb = 24'h0;
  endtask

  task automatic model_edge();
    bit          act;
    logic [23:0] px;
    logic [23:0] mask;
    int          vt;
    if (reset) return;
    if (m_ce) begin
      act  = (m_h < H_ACTIVE) && (m_v < V_ACTIVE);
      e_hb = (m_h >= H_ACTIVE);
      e_vb = (m_v >= V_ACTIVE);
      e_hs = (m_h >= H_ACTIVE + H_FP) && (m_h < H_ACTIVE + H_FP + H_SYNC);
      e_vs = (m_v >= V_ACTIVE + V_FP) && (m_v < V_ACTIVE + V_FP + V_SYNC);
      px   = 24'h0;
      case (m_mode)
        0: px = {3{m_lfsr[15:8]}};
        1: px = act ? bar_colour(m_h / (H_ACTIVE / 8)) : 24'h0;
        2: px = ((m_h % 16 == 0) || (m_v % 16 == 0) || (m_h == H_ACTIVE - 1) ||
                 (m_v == V_ACTIVE - 1)) ? 24'hFFFFFF : 24'h0;
        default: px = {8'(m_h), 8'(m_v), 8'(m_frame)};
      endcase
      if (!act) px = 24'h0;
      mask  = {{8{vid.col_mask[2]}}, {8{vid.col_mask[1]}}, {8{vid.col_mask[0]}}};
      e_rgb = px & mask;
      m_lfsr = lfsr_step(m_lfsr);
      vt = V_TOT + (m_pal ? PAL_EXTRA : 0);
      m_h++;
      if (m_h == H_TOT) begin
        m_h = 0;
        m_v++;
        if (m_v == vt) begin
          m_v     = 0;
          m_frame = (m_frame + 1) % 256;
          m_pal   = vid.pal;
          m_mode  = int'(vid.mode);
        end
      end
    end
    m_cyc++;
    m_ce = (m_cyc % CE_DIV == 0);
  endtask

  task automatic compare();
    check("timing",
          64'({vid.ce_pix, vid.hblank, vid.vblank, vid.hsync, vid.vsync,
               vid.hcnt, vid.vcnt, vid.frame_cnt}),
          64'({m_ce, e_hb, e_vb, e_hs, e_vs, 16'(m_h), 16'(m_v), 8'(m_frame)}));
    check("rgb", 64'({vid.r, vid.g, vid.b}), 64'(e_rgb));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  // Asserts reset away from a clock edge; outputs must clear immediately
  task automatic do_reset(input int hold);
    reset = 1'b1;
    #1;
    model_reset();
    check("reset_rgb", 64'({vid.r, vid.g, vid.b}), 64'(0));
    check("reset_timing",
          64'({vid.ce_pix, vid.hblank, vid.vblank, vid.hsync, vid.vsync,
               vid.hcnt, vid.vcnt, vid.frame_cnt}), 64'(0));
    repeat (hold) cycle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_frame();
    logic [7:0] start;
    int n;
    start = vid.frame_cnt;
    n = 0;
    while (vid.frame_cnt == start && n < 2000) begin
      cycle();
      n++;
    end
    if (n >= 2000) check("frame_timeout", 64'(vid.frame_cnt), 64'(start + 8'd1));
  endtask

  // Counts pixel enables until frame_cnt next changes; optionally raises pal
  task automatic measure(input int pal_at, output int n);
    logic [7:0] start;
    start = vid.frame_cnt;
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      cycle();
      if (vid.frame_cnt != start) break;
      if (vid.ce_pix) begin
        if (n == pal_at) vid.pal = 1'b1;
        n++;
      end
    end
    check("frame_inc", 64'(vid.frame_cnt), 64'(start + 8'd1));
  endtask

  // Waits until the registered outputs hold pixel (h,v) of frame f
  task automatic wait_pix(input int h, input int v, input int f);
    int n;
    n = 0;
    while (!(vid.hcnt == 16'(h + 1) && vid.vcnt == 16'(v) && vid.frame_cnt == 8'(f))
           && n < 20000) begin
      cycle();
      n++;
    end
    if (n >= 20000)
      check("pix_timeout", 64'({vid.hcnt, vid.vcnt, vid.frame_cnt}),
            64'({16'(h + 1), 16'(v), 8'(f)}));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int f;
    vid.pal = 1'b0;
    vid.mode = 2'd0;
    vid.col_mask = 3'd7;
    model_reset();
    #2;
    do_reset(3);

    // First enables after reset, first noise pixel
    for (int k = 1; k <= 4; k++) begin
      cycle();
      check("ce_pulse", 64'(vid.ce_pix), 64'(k % 2 == 0));
      if (k == 3) check("noise_first", 64'({vid.r, vid.g, vid.b}), 64'(24'hACACAC));
    end

    // Noise over more than 1000 pixels
    repeat (2400) cycle();

    // Frame lengths, pal raised mid-frame
    wait_frame();
    measure(-1, n);
    check("frame_ntsc", 64'(n), 64'(H_TOT * V_TOT));
    measure(100, n);
    check("frame_pal_switch", 64'(n), 64'(H_TOT * V_TOT));
    measure(-1, n);
    check("frame_pal", 64'(n), 64'(H_TOT * (V_TOT + PAL_EXTRA)));
    vid.pal = 1'b0;

    // Colour bars
    vid.mode = 2'd1;
    vid.col_mask = 3'd7;
    wait_frame();
    f = int'(vid.frame_cnt);
    for (int i = 0; i < 8; i++) begin
      wait_pix(2 * i, 1, f);
      check("bar", 64'({vid.r, vid.g, vid.b}), 64'(bar_colour(i)));
    end
    vid.col_mask = 3'b010;
    wait_pix(0, 2, f);
    check("bar_mask_white", 64'({vid.r, vid.g, vid.b}), 64'(24'h00FF00));
    wait_pix(10, 2, f);
    check("bar_mask_red", 64'({vid.r, vid.g, vid.b}), 64'(24'h000000));

    // Mid-line reset, then gradient and grid
    wait_pix(7, 3, f);
    do_reset(3);
    vid.mode = 2'd3;
    vid.col_mask = 3'd7;
    wait_pix(3, 2, 5);
    check("gradient", 64'({vid.r, vid.g, vid.b}), 64'({8'd3, 8'd2, 8'd5}));
    vid.mode = 2'd2;
    wait_pix(5, 0, 6);
    check("grid_5_0", 64'({vid.r, vid.g, vid.b}), 64'(24'hFFFFFF));
    wait_pix(0, 5, 6);
    check("grid_0_5", 64'({vid.r, vid.g, vid.b}), 64'(24'hFFFFFF));
    wait_pix(5, 5, 6);
    check("grid_5_5", 64'({vid.r, vid.g, vid.b}), 64'(24'h000000));

    // Randomized controls with one mid-frame reset
    for (int s = 0; s < 30; s++) begin
      vid.mode     = 2'($urandom_range(0, 3));
      vid.col_mask = 3'($urandom_range(0, 7));
      vid.pal      = 1'($urandom_range(0, 1));
      n = int'($urandom_range(50, 600));
      if (s == 15) do_reset(int'($urandom_range(1, 4)));
      repeat (n) cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
Parametrised video timing and test-pattern generator. It is the next generation of the single-mode core pattern source behind emu. It produces pixel-enable, blank and sync timing for a configurable raster, with NTSC/PAL line count selection. It also generates four selectable patterns (LFSR noise, colour bars, grid, gradient) with per-channel colour masking. It drives CE_PIXEL, VGA_DE, VGA_HS, VGA_VS and VGA_R/G/B directly from the emu top.

Parameters:
DW, 8, bits per colour channel (4..16)
CE_DIV, 4, clk cycles per pixel enable (>=1; 1 = ce_pix always high after reset)
H_ACTIVE, 320, active pixels per line (multiple of 8)
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 32, hsync width (pixels)
H_BP, 32, horizontal back porch (pixels)
V_ACTIVE, 240, active lines
V_FP, 4, vertical front porch (lines)
V_SYNC, 3, vsync width (lines)
V_BP, 15, vertical back porch (lines)
PAL_EXTRA, 50, extra back-porch lines added when PAL is selected

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pal  in  1  0=NTSC line count, 1=PAL (adds PAL_EXTRA lines)
mode  in  2  0=noise, 1=colour bars, 2=grid, 3=gradient
col_mask  in  3  channel enables {R,G,B}; 0 forces channel to 0
ce_pix  out  1  pixel clock enable
hblank  out  1  horizontal blank
vblank  out  1  vertical blank
hsync  out  1  horizontal sync, active high
vsync  out  1  vertical sync, active high
r  out  DW  red
g  out  DW  green
b  out  DW  blue
hcnt  out  16  current pixel counter (debug)
vcnt  out  16  current line counter (debug)
frame_cnt  out  8  frame counter, wraps 255->0

Behaviour:
- Reset: all outputs 0; ce divider 0; hcnt=vcnt=0; LFSR=16'hACE1; latched pal/mode = 0.
- Only the asynchronous reset is used; no synchronous clears.
- ce_pix is registered. It is high for one clk every CE_DIV clks. The first pulse comes on the CE_DIV-th rising edge after reset deasserts.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP+(pal_l ? PAL_EXTRA : 0).
- Counters advance only in cycles where ce_pix=1.
- hcnt wraps H_TOTAL-1 -> 0. vcnt increments on hcnt wrap and wraps V_TOTAL-1 -> 0.
- At vcnt wrap: frame_cnt increments; pal_l and mode_l latch pal and mode. Mid-frame changes to pal/mode have no effect until the next frame.
- Pipeline, latency 1 ce_pix: in a ce_pix cycle with counters (h,v), the output registers load values computed from (h,v) and the counters then advance. Outputs hold between enables.
- hblank = h>=H_ACTIVE. vblank = v>=V_ACTIVE.
- hsync = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
- vsync = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
- r/g/b = 0 whenever hblank|vblank, then ANDed with col_mask.
- Noise: 16-bit Fibonacci LFSR, taps 16,14,13,11, shifts left with feedback into bit0. It advances on every ce_pix, blanking included. All three channels = lfsr[15:16-DW], masked per channel.
- Colour bars: bar index 0..7, bar width H_ACTIVE/8. The index comes from a bar sub-counter reset at h=0, with no divider.
  - R full-scale for idx {0,1,4,5}; G for {0,1,2,3}; B for {0,2,4,6}.
  - Full-scale = all ones; otherwise 0.
  - Order: white, yellow, cyan, green, magenta, red, blue, black.
- Grid: all channels all-ones when h[3:0]==0 or v[3:0]==0 or h==H_ACTIVE-1 or v==V_ACTIVE-1; else 0.
- Gradient: r=h[DW-1:0], g=v[DW-1:0], b=frame_cnt zero-extended/truncated to DW.
- Reset mid-frame: all state returns to reset values immediately. Timing restarts at h=v=0 with NTSC/noise until the first frame wrap.

Test Plan:
- Shared bench params: DW=8, CE_DIV=2, H_ACTIVE=16, H_FP=2, H_SYNC=2, H_BP=4, V_ACTIVE=8, V_FP=1, V_SYNC=1, V_BP=2, PAL_EXTRA=2.
- Reset release -> ce_pix first high on 2nd edge, then every 2 clks. All outputs 0 during reset. Assert reset mid-line -> outputs 0 same cycle (asynchronous).
- Timing, free run, pal=0 -> hsync high for exactly 2 pixels at h=18,19. hblank for 8 pixels/line. Line = 24 pixels = 48 clks. vsync at line 9. Frame = 12 lines.
- pal=1 asserted mid-frame -> current frame stays 12 lines; next frame is 14 lines; frame_cnt increments once per frame.
- mode=1, col_mask=7 -> active line 2 pixels per bar: (FF,FF,FF),(FF,FF,00),(00,FF,FF),(00,FF,00),(FF,00,FF),(FF,00,00),(00,00,FF),(00,00,00). col_mask=3'b010 -> only g nonzero.
- mode=0 -> first output pixel after reset = 8'hAC on r/g/b. Sequence matches reference LFSR model for 1000 pixels; rgb=0 during blanking.
- mode=3 at frame_cnt=5 -> pixel (h=3,v=2) gives r=3, g=2, b=5. mode=2 -> pixel (0,5) and (5,0) all-ones; pixel (5,5) zero.
